crc8_serial: RTL and testbench
==============================

Name: crc8_serial

Overview:
- Bit-serial CRC-8 generator/checker: an LFSR that absorbs one message bit per enabled clock, MSB-first.
- Sits beside the UART-style receiver. The receiver clears it at frame start, shifts in frame bits, then compares or inspects the remainder for CRC errors.
- Also usable as a generator: after the message bits, crc_out holds the 8-bit check value to transmit.

Parameters:
- POLY, 8'h07, generator polynomial without the implicit x^8 term (x^8+x^2+x+1).
- INIT, 8'h00, remainder value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; loads INIT and clears the counter.
- enable  input  1  when 1, absorb din this cycle; when 0, hold state.
- din  input  1  serial message bit, MSB of each byte first.
- crc_out  output  8  current remainder register.
- zero  output  1  combinational, 1 when crc_out == 8'h00.
- bit_count  output  8  number of bits absorbed since reset, saturating at 8'hFF.

Behaviour:
- Positional port order is fixed as enable, clk, reset, din, crc_out, zero, bit_count; existing instantiations are positional on the first five.
- Reset (async, active-low):
  - crc_out = INIT and bit_count = 0 immediately on reset falling, independent of clk.
  - zero reflects INIT, so it is 1 with the defaults.
  - Reset mid-message discards all absorbed bits at once.
  - While reset is low, enable and din are ignored.
- Update on rising clk with reset high and enable = 1:
  - fb = crc_out[7] ^ din.
  - crc_out <= {crc_out[6:0], 1'b0} ^ (fb ? POLY : 8'h00).
  - bit_count <= bit_count + 1, saturating at 255 (no wrap).
- enable = 0: crc_out and bit_count hold; din is don't-care.
- Latency:
  - crc_out reflects a bit one clock after the edge that samples it.
  - zero is combinational from crc_out, with no extra cycle.
- Algorithm:
  - No input or output reflection and no final XOR; this is CRC-8/SMBUS with the defaults.
  - Check value: "123456789" → 8'hF4.
- Residue property:
  - Feed message bits, then the 8 CRC bits MSB-first, with INIT = 0.
  - A correct frame leaves crc_out = 0 and zero = 1; any single-bit error leaves zero = 0.
- Operand widths:
  - All arithmetic is 8-bit.
  - bit_count saturates rather than wrapping, so frames longer than 255 bits still compute the correct CRC; only the count stops at 255.
- No X propagation:
  - With reset released and enable = 0, outputs stay stable for any din.
  - The design needs a reset before use; it has no initial-block dependence.

Test Plan:
- Assert reset low mid-cycle, with clk idle → crc_out = 8'h00, zero = 1, bit_count = 0 without any clk edge.
- Shift byte 8'h01 MSB-first with enable = 1 for 8 clocks → crc_out = 8'h07, bit_count = 8; shift 8'h80 after a fresh reset → crc_out = 8'h89.
- Shift ASCII "123456789" (72 bits) → crc_out = 8'hF4, bit_count = 72.
- Shift 8'h01, then 8'h07 (its CRC) → crc_out = 8'h00, zero = 1; flip one bit of the appended CRC → zero = 0.
- Interleave enable = 0 gaps with random din during the 8'h80 byte → final crc_out still 8'h89, bit_count = 8.
- Shift 300 bits → bit_count = 255 (saturated), and crc_out matches a software model.
- Assert reset low after 4 bits of a byte, then release and shift 8'h01 → crc_out = 8'h07.

Source files
------------

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 LFSR, MSB-first, one message bit absorbed per enabled clock.
// Defaults give CRC-8/SMBUS (no reflection, no final XOR); bit_count saturates at 255.
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       enable,
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] crc_out,
  output logic       zero,
  output logic [7:0] bit_count
);

  logic [7:0] r_crc;
  logic [7:0] r_count;
  logic       w_fb;
  logic [7:0] w_crc_next;
  logic       w_count_full;

  assign w_fb         = r_crc[7] ^ din;
  assign w_crc_next   = {r_crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);
  assign w_count_full = (r_count == 8'hFF);

  // Count stops at 255 so long frames keep a correct CRC without wrapping the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc   <= INIT;
      r_count <= 8'h00;
    end else if (enable) begin
      r_crc <= w_crc_next;
      if (!w_count_full) begin
        r_count <= r_count + 8'h01;
      end
    end
  end

  assign crc_out   = r_crc;
  assign zero      = (r_crc == 8'h00);
  assign bit_count = r_count;

endmodule

// File: tb/tb_crc8_serial.sv
// Directed + random bench for crc8_serial; expected CRCs come from polynomial
// long division over the queued message bits.
module tb_crc8_serial;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset;
  logic       enable;
  logic       din;
  logic [7:0] crc_out;
  logic       zero;
  logic [7:0] bit_count;

  int total = 0;
  int bad   = 0;
  logic msg_q[$];

  crc8_serial #(.POLY(8'h07), .INIT(8'h00)) dut (
    .enable   (enable),
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .crc_out  (crc_out),
    .zero     (zero),
    .bit_count(bit_count)
  );

  always #5 if (clk_en) clk = ~clk;

  // Remainder of M(x) * x^8 divided by x^8+x^2+x+1, done as textbook mod-2 long division.
  function automatic logic [7:0] model_crc(input logic q[$]);
    logic       a[$];
    logic [8:0] gen;
    logic [7:0] rem;
    int         n;
    gen = 9'h107;
    a   = q;
    n   = q.size();
    for (int k = 0; k < 8; k++) a.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        for (int j = 0; j <= 8; j++) a[i+j] = a[i+j] ^ gen[8-j];
      end
    end
    rem = 8'h00;
    for (int k = 0; k < 8; k++) rem[7-k] = a[n+k];
    return rem;
  endfunction

  function automatic logic [7:0] model_count(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".crc"},   32'(crc_out),   32'(model_crc(msg_q)));
    chk({tag, ".count"}, 32'(bit_count), 32'(model_count(msg_q.size())));
    chk({tag, ".zero"},  32'(zero),      32'(model_crc(msg_q) == 8'h00));
    $display("frame %s: bits=%0d crc=%02h count=%0d zero=%0b", tag, msg_q.size(),
             crc_out, bit_count, zero);
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic put_bit(input logic b);
    enable = 1'b1;
    din    = b;
    msg_q.push_back(b);
    @(negedge clk);
    enable = 1'b0;
    din    = 1'($urandom);
  endtask

  task automatic shift_byte(input logic [7:0] b, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      put_bit(b[i]);
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          din = 1'($urandom);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    msg_q.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] s[9];
    logic [7:0] c;
    logic       frame[$];
    int         flip;
    int         len;

    reset  = 1'b1;
    enable = 1'b0;
    din    = 1'b0;

    // Reset with the clock stopped: outputs must settle with no edge at all.
    #3 reset = 1'b0;
    din    = 1'b1;
    enable = 1'b1;
    #1;
    chk("rst_noclk.crc",   32'(crc_out),   32'h00);
    chk("rst_noclk.zero",  32'(zero),      32'h1);
    chk("rst_noclk.count", 32'(bit_count), 32'h00);
    enable = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    shift_byte(8'h01, 1'b0);
    chk("byte01.crc", 32'(crc_out), 32'h07);
    chk("byte01.count", 32'(bit_count), 32'd8);
    check_state("byte01");

    do_reset();
    shift_byte(8'h80, 1'b0);
    chk("byte80.crc", 32'(crc_out), 32'h89);

    do_reset();
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    foreach (s[i]) shift_byte(s[i], 1'b0);
    chk("check.crc", 32'(crc_out), 32'hF4);
    chk("check.count", 32'(bit_count), 32'd72);
    check_state("check");

    do_reset();
    shift_byte(8'h01, 1'b0);
    shift_byte(8'h07, 1'b0);
    chk("residue.crc", 32'(crc_out), 32'h00);
    chk("residue.zero", 32'(zero), 32'h1);

    do_reset();
    shift_byte(8'h01, 1'b0);
    shift_byte(8'h06, 1'b0);
    chk("residue_err.zero", 32'(zero), 32'h0);

    // Random frames with appended CRC: intact -> zero, one flipped bit -> nonzero.
    for (int t = 0; t < 4; t++) begin
      frame.delete();
      len = $urandom_range(8, 40);
      for (int i = 0; i < len; i++) frame.push_back(1'($urandom));
      c = model_crc(frame);
      for (int i = 7; i >= 0; i--) frame.push_back(c[i]);
      flip = (t % 2 == 1) ? int'($urandom_range(0, len + 7)) : -1;
      if (flip >= 0) frame[flip] = ~frame[flip];
      do_reset();
      foreach (frame[i]) put_bit(frame[i]);
      chk($sformatf("rand_residue%0d.zero", t), 32'(zero), (flip < 0) ? 32'h1 : 32'h0);
      check_state($sformatf("rand_residue%0d", t));
    end

    do_reset();
    shift_byte(8'h80, 1'b1);
    chk("gaps.crc", 32'(crc_out), 32'h89);
    chk("gaps.count", 32'(bit_count), 32'd8);

    do_reset();
    for (int i = 0; i < 300; i++) put_bit(1'($urandom));
    chk("sat.count", 32'(bit_count), 32'd255);
    check_state("sat300");

    // Mid-byte reset with the clock parked low must discard the partial byte at once.
    do_reset();
    shift_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    clk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst.crc",   32'(crc_out),   32'h00);
    chk("midrst.count", 32'(bit_count), 32'h00);
    msg_q.delete();
    clk_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    shift_byte(8'h01, 1'b0);
    chk("midrst_then01.crc", 32'(crc_out), 32'h07);
    check_state("midrst_then01");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
